cascaded_up_down_counter: RTL and testbench

- Parametrised successor to the single-stage terminal-count counter.
- Chains STAGES counter stages of WIDTH bits each. Every stage has its own runtime terminal value, and each stage's wrap advances the next stage (for example, a seconds/minutes/hours timebase).
- Adds up/down mode, synchronous parallel load and an all-stages-wrap flag.
- Sits under the top-level timer wrappers and is driven by a single enable tick.

---
 rtl/cascaded_up_down_counter_pkg.sv | 10 +
 rtl/cascaded_up_down_counter_stage.sv | 28 ++
 rtl/cascaded_up_down_counter.sv | 40 ++++
 tb/tb_cascaded_up_down_counter.sv | 107 ++++++++++
 4 files changed

// File: rtl/cascaded_up_down_counter_pkg.sv
// cascaded_up_down_counter_pkg: shared defaults, mode encoding and bus-slice helper
package cascaded_up_down_counter_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STAGES = 3;
  localparam logic MODE_UP = 1'b0;
  localparam logic MODE_DOWN = 1'b1;
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/cascaded_up_down_counter_stage.sv
// cascaded_up_down_counter_stage: one up/down stage (clk, rst, adv_i, down_i, load_i, load_val_i, max_i -> count_o, term_o)
module cascaded_up_down_counter_stage
  import cascaded_up_down_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  input  logic             down_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] count_o,
  output logic             term_o
);
  logic [WIDTH-1:0] count_q, count_d, wrap_val, step_val;
  logic down;
  assign down = (down_i == MODE_DOWN);
  assign term_o = down ? (count_q == '0) : (count_q >= max_i);
  assign wrap_val = down ? max_i : '0;
  assign step_val = down ? count_q - 1'b1 : count_q + 1'b1;
  assign count_d = load_i ? load_val_i : adv_i ? (term_o ? wrap_val : step_val) : count_q;
  assign count_o = count_q;
  always_ff @(posedge clk) begin
    count_q <= rst ? '0 : count_d;
  end
endmodule

// File: rtl/cascaded_up_down_counter.sv
// cascaded_up_down_counter: STAGES chained up/down counters (clock, reset, io_en, io_down, io_load, io_load_val, io_count_max -> io_count, io_clr, io_all_wrap)
module cascaded_up_down_counter
  import cascaded_up_down_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_en,
  input  logic                    io_down,
  input  logic                    io_load,
  input  logic [STAGES*WIDTH-1:0] io_load_val,
  input  logic [STAGES*WIDTH-1:0] io_count_max,
  output logic [STAGES*WIDTH-1:0] io_count,
  output logic [STAGES-1:0]       io_clr,
  output logic                    io_all_wrap
);
  logic [STAGES-1:0] adv, term;
  always_comb begin
    adv = '0;
    adv[0] = io_en;
    for (int i = 1; i < STAGES; i++) adv[i] = adv[i-1] & term[i-1];
  end
  assign io_clr = adv & term & {STAGES{~(reset | io_load)}};
  assign io_all_wrap = io_clr[STAGES-1];
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    cascaded_up_down_counter_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clock),
      .rst        (reset),
      .adv_i      (adv[g]),
      .down_i     (io_down),
      .load_i     (io_load),
      .load_val_i (io_load_val[slice_lo(g, WIDTH) +: WIDTH]),
      .max_i      (io_count_max[slice_lo(g, WIDTH) +: WIDTH]),
      .count_o    (io_count[slice_lo(g, WIDTH) +: WIDTH]),
      .term_o     (term[g])
    );
  end
endmodule

// File: tb/tb_cascaded_up_down_counter.sv
// tb_cascaded_up_down_counter: randomized and directed check against a ripple-carry reference model
module tb_cascaded_up_down_counter;
  logic clock = 1'b0;
  logic reset, io_en, io_down, io_load;
  logic [23:0] io_load_val, io_count_max, io_count;
  logic [2:0] io_clr;
  logic io_all_wrap;
  int total = 0;
  int bad = 0;
  int m[3] = '{0, 0, 0};
  localparam logic [23:0] MAX = {8'd23, 8'd59, 8'd59};
  cascaded_up_down_counter #(.WIDTH(8), .STAGES(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_en        (io_en),
    .io_down      (io_down),
    .io_load      (io_load),
    .io_load_val  (io_load_val),
    .io_count_max (io_count_max),
    .io_count     (io_count),
    .io_clr       (io_clr),
    .io_all_wrap  (io_all_wrap)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int fld(input logic [23:0] v, input int i);
    return int'(v[i*8 +: 8]);
  endfunction
  task automatic cyc(input logic r, input logic l, input logic e, input logic d,
                     input logic [23:0] lv, input logic [23:0] mx);
    int n[3];
    logic [2:0] ec;
    bit carry;
    int lim;
    reset = r; io_load = l; io_en = e; io_down = d; io_load_val = lv; io_count_max = mx;
    #1;
    n = m;
    ec = '0;
    carry = e;
    for (int i = 0; i < 3; i++) begin
      if (carry) begin
        lim = fld(mx, i);
        if (d ? (n[i] == 0) : (n[i] >= lim)) begin
          n[i] = d ? lim : 0;
          ec[i] = 1'b1;
        end else begin
          n[i] = d ? n[i] - 1 : n[i] + 1;
          carry = 0;
        end
      end
    end
    if (r || l) ec = '0;
    if (r) n = '{0, 0, 0};
    else if (l) for (int i = 0; i < 3; i++) n[i] = fld(lv, i);
    check("clr", 32'(io_clr), 32'(ec));
    check("all_wrap", 32'(io_all_wrap), 32'(ec[2]));
    @(posedge clock);
    #1;
    m = n;
    check("count", 32'(io_count), {8'd0, n[2][7:0], n[1][7:0], n[0][7:0]});
    @(negedge clock);
  endtask
  initial begin
    logic r, l, e, d;
    logic [23:0] mx;
    @(negedge clock);
    cyc(1, 0, 0, 0, '0, MAX);
    check("reset_count", 32'(io_count), 32'h0);
    for (int k = 0; k < 60; k++) cyc(0, 0, 1, 0, '0, MAX);
    check("after60", 32'(io_count), 32'h000100);
    cyc(0, 1, 0, 0, {8'd23, 8'd59, 8'd58}, MAX);
    cyc(0, 0, 1, 0, '0, MAX);
    cyc(0, 0, 1, 0, '0, MAX);
    check("full_wrap_up", 32'(io_count), 32'h0);
    cyc(0, 1, 0, 1, '0, MAX);
    cyc(0, 0, 1, 1, '0, MAX);
    check("full_wrap_down", 32'(io_count), 32'h173B3B);
    cyc(0, 1, 0, 0, {8'd0, 8'd0, 8'd200}, MAX);
    cyc(0, 0, 1, 0, '0, MAX);
    check("out_of_range", 32'(io_count), 32'h000100);
    cyc(0, 1, 0, 0, {8'd0, 8'd0, 8'd59}, MAX);
    cyc(0, 1, 1, 0, {8'd0, 8'd0, 8'd5}, MAX);
    check("load_beats_en", 32'(io_count), 32'h000005);
    cyc(1, 1, 1, 0, {8'd7, 8'd7, 8'd7}, MAX);
    check("reset_beats_load", 32'(io_count), 32'h0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, '0, {8'd23, 8'd59, 8'd0});
    check("max0", 32'(io_count), 32'h000400);
    d = 0;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) d = ~d;
      mx = ($urandom_range(0, 9) == 0) ?
           {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))} : MAX;
      cyc(r, l, e, d, 24'($urandom), mx);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
